// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_pkg: shared FSM state encoding, feed-length rule and lane-slice index helpers for the skew feeder.
package systolic_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;
  function automatic int feed_len(input int m, input int n, input int l);
    return n + ((m > l) ? m : l) - 1;
  endfunction
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  // Inner index a lane consumes at slice t: lane i is delayed by i cycles.
  function automatic int lane_k(input int t, input int lane);
    return t - lane;
  endfunction
  function automatic logic lane_ok(input int t, input int lane, input int n);
    return (lane_k(t, lane) >= 0) && (lane_k(t, lane) < n);
  endfunction
endpackage

// File: rtl/systolic_skew_feeder_store.sv
// systolic_operand_store: A/B register arrays with write ports and per-lane read muxes.
// A write landing on the same edge as a read of that word is forwarded, so write+start feeds fresh data.
module systolic_operand_store
  import systolic_pkg::*;
#(
  parameter int WIDTH_left = 4,
  parameter int WIDTH_up   = 4,
  parameter int Mritx_M    = 3,
  parameter int Mritx_N    = 4,
  parameter int Mritx_L    = 3,
  parameter int AWL        = idx_w(Mritx_M * Mritx_N),
  parameter int AWU        = idx_w(Mritx_N * Mritx_L)
) (
  input  logic                             clk,
  input  logic                             we_l,
  input  logic [AWL-1:0]                   wa_l,
  input  logic [WIDTH_left-1:0]            wd_l,
  input  logic                             we_u,
  input  logic [AWU-1:0]                   wa_u,
  input  logic [WIDTH_up-1:0]              wd_u,
  input  logic [Mritx_M-1:0][AWL-1:0]      ra_l,
  input  logic [Mritx_L-1:0][AWU-1:0]      ra_u,
  output logic [Mritx_M*WIDTH_left-1:0]    rd_l,
  output logic [Mritx_L*WIDTH_up-1:0]      rd_u
);
  logic [WIDTH_left-1:0] a_q [Mritx_M*Mritx_N];
  logic [WIDTH_up-1:0]   b_q [Mritx_N*Mritx_L];

  always_ff @(posedge clk) begin
    if (we_l) a_q[wa_l] <= wd_l;
    if (we_u) b_q[wa_u] <= wd_u;
  end

  for (genvar i = 0; i < Mritx_M; i++) begin : g_rl
    assign rd_l[i*WIDTH_left +: WIDTH_left] = (we_l && wa_l == ra_l[i]) ? wd_l : a_q[ra_l[i]];
  end

  for (genvar j = 0; j < Mritx_L; j++) begin : g_ru
    assign rd_u[j*WIDTH_up +: WIDTH_up] = (we_u && wa_u == ra_u[j]) ? wd_u : b_q[ra_u[j]];
  end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: operand store plus diagonal-skew sequencer feeding a systolic multiplier.
// Optional SKEW_FEEDER_PERF_CNT_EN adds a saturating busy-cycle counter on cycle_cnt.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH_left      = 4,
  parameter int WIDTH_up        = 4,
  parameter int Mritx_M         = 3,
  parameter int Mritx_N         = 4,
  parameter int Mritx_L         = 3,
  parameter int Mritx_LOG2_size = 10,
  parameter int DRAIN           = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_left,
  input  logic [Mritx_LOG2_size-1:0]    wr_addr_l,
  input  logic [WIDTH_left-1:0]         wr_data_l,
  input  logic                          wr_en_up,
  input  logic [Mritx_LOG2_size-1:0]    wr_addr_u,
  input  logic [WIDTH_up-1:0]           wr_data_u,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          wr_err,
  output logic [Mritx_M*WIDTH_left-1:0] left,
  output logic [Mritx_L*WIDTH_up-1:0]   up,
  output logic [Mritx_M-1:0]            valid_left,
  output logic [Mritx_L-1:0]            valid_up,
  output logic [15:0]                   cycle_cnt
);
  localparam int T   = feed_len(Mritx_M, Mritx_N, Mritx_L);
  localparam int CW  = Mritx_LOG2_size;
  localparam int AWL = idx_w(Mritx_M * Mritx_N);
  localparam int AWU = idx_w(Mritx_N * Mritx_L);

  state_e                        state_q;
  logic [CW-1:0]                 t_q, d_q, t_nx;
  logic                          busy_q, done_q, wr_err_q;
  logic                          accept, feed_nx, ok_l, ok_u;
  logic [Mritx_M*WIDTH_left-1:0] left_q, left_d, rd_l;
  logic [Mritx_L*WIDTH_up-1:0]   up_q, up_d, rd_u;
  logic [Mritx_M-1:0]            vl_q, vl_d;
  logic [Mritx_L-1:0]            vu_q, vu_d;
  logic [Mritx_M-1:0][AWL-1:0]   ra_l;
  logic [Mritx_L-1:0][AWU-1:0]   ra_u;

  assign accept  = state_q == S_IDLE && start;
  assign ok_l    = state_q == S_IDLE && wr_addr_l < CW'(Mritx_M * Mritx_N);
  assign ok_u    = state_q == S_IDLE && wr_addr_u < CW'(Mritx_N * Mritx_L);
  // Output registers load the slice of the coming cycle, so it lines up with t_q.
  assign t_nx    = accept ? '0 : t_q + 1'b1;
  assign feed_nx = accept || (state_q == S_FEED && int'(t_q) != T - 1);

  for (genvar i = 0; i < Mritx_M; i++) begin : g_l
    logic ok;
    assign ok      = feed_nx && lane_ok(int'(t_nx), i, Mritx_N);
    assign ra_l[i] = ok ? AWL'(i * Mritx_N + lane_k(int'(t_nx), i)) : '0;
    assign vl_d[i] = ok;
    assign left_d[i*WIDTH_left +: WIDTH_left] = ok ? rd_l[i*WIDTH_left +: WIDTH_left] : '0;
  end

  for (genvar j = 0; j < Mritx_L; j++) begin : g_u
    logic ok;
    assign ok      = feed_nx && lane_ok(int'(t_nx), j, Mritx_N);
    assign ra_u[j] = ok ? AWU'(lane_k(int'(t_nx), j) * Mritx_L + j) : '0;
    assign vu_d[j] = ok;
    assign up_d[j*WIDTH_up +: WIDTH_up] = ok ? rd_u[j*WIDTH_up +: WIDTH_up] : '0;
  end

  systolic_operand_store #(
    .WIDTH_left(WIDTH_left),
    .WIDTH_up  (WIDTH_up),
    .Mritx_M   (Mritx_M),
    .Mritx_N   (Mritx_N),
    .Mritx_L   (Mritx_L),
    .AWL       (AWL),
    .AWU       (AWU)
  ) u_store (
    .clk (clk),
    .we_l(wr_en_left && ok_l),
    .wa_l(wr_addr_l[AWL-1:0]),
    .wd_l(wr_data_l),
    .we_u(wr_en_up && ok_u),
    .wa_u(wr_addr_u[AWU-1:0]),
    .wd_u(wr_data_u),
    .ra_l(ra_l),
    .ra_u(ra_u),
    .rd_l(rd_l),
    .rd_u(rd_u)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      left_q   <= '0;
      up_q     <= '0;
      vl_q     <= '0;
      vu_q     <= '0;
    end else begin
      wr_err_q <= (wr_en_left && !ok_l) || (wr_en_up && !ok_u);
      left_q   <= left_d;
      up_q     <= up_d;
      vl_q     <= vl_d;
      vu_q     <= vu_d;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_FEED;
          t_q     <= '0;
          busy_q  <= 1'b1;
        end
        S_FEED: if (int'(t_q) == T - 1) begin
          state_q <= (DRAIN == 0) ? S_DONE : S_DRAIN;
          d_q     <= '0;
          done_q  <= DRAIN == 0;
        end else t_q <= t_q + 1'b1;
        S_DRAIN: if (int'(d_q) == DRAIN - 1) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else d_q <= d_q + 1'b1;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SKEW_FEEDER_PERF_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (busy_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
  end
  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_err     = wr_err_q;
  assign left       = left_q;
  assign up         = up_q;
  assign valid_left = vl_q;
  assign valid_up   = vu_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: table-driven write checks plus feed sequences checked against a matrix-level model.
module tb_systolic_skew_feeder;
  localparam int M = 3, N = 4, L = 3, W = 4, AW = 10, DR = 5;
  localparam int T = N + ((M > L) ? M : L) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_en_left = 1'b0, wr_en_up = 1'b0, start = 1'b0;
  logic [AW-1:0] wr_addr_l = '0, wr_addr_u = '0;
  logic [W-1:0] wr_data_l = '0, wr_data_u = '0;
  logic busy, done, wr_err;
  logic [M*W-1:0] left;
  logic [L*W-1:0] up;
  logic [M-1:0] valid_left;
  logic [L-1:0] valid_up;
  logic [15:0] cycle_cnt;

  int n_pass = 0, n_tot = 0;
  logic [W-1:0] a_m [M][N];
  logic [W-1:0] b_m [N][L];

  typedef struct {
    bit el; int al; int dl;
    bit eu; int au; int du;
    bit err;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .WIDTH_left(W), .WIDTH_up(W), .Mritx_M(M), .Mritx_N(N), .Mritx_L(L),
    .Mritx_LOG2_size(AW), .DRAIN(DR)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en_left(wr_en_left), .wr_addr_l(wr_addr_l), .wr_data_l(wr_data_l),
    .wr_en_up(wr_en_up), .wr_addr_u(wr_addr_u), .wr_data_u(wr_data_u),
    .start(start), .busy(busy), .done(done), .wr_err(wr_err),
    .left(left), .up(up), .valid_left(valid_left), .valid_up(valid_up),
    .cycle_cnt(cycle_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input bit el, input int al, input int dl, input bit eu, input int au, input int du);
    wr_en_left = el; wr_addr_l = AW'(al); wr_data_l = W'(dl);
    wr_en_up   = eu; wr_addr_u = AW'(au); wr_data_u = W'(du);
    if (el && al < M*N) a_m[al/N][al%N] = W'(dl);
    if (eu && au < N*L) b_m[au/L][au%L] = W'(du);
  endtask

  // Cycle c counts cycles after the edge that accepted start.
  task automatic check_cycle(input int c, input string tag);
    logic [M*W-1:0] el;
    logic [L*W-1:0] eu;
    logic [M-1:0] evl;
    logic [L-1:0] evu;
    el = '0; eu = '0; evl = '0; evu = '0;
    for (int i = 0; i < M; i++)
      if (c < T && c - i >= 0 && c - i < N) begin evl[i] = 1'b1; el[i*W +: W] = a_m[i][c-i]; end
    for (int j = 0; j < L; j++)
      if (c < T && c - j >= 0 && c - j < N) begin evu[j] = 1'b1; eu[j*W +: W] = b_m[c-j][j]; end
    chk($sformatf("%s c%0d left", tag, c), 32'(left), 32'(el));
    chk($sformatf("%s c%0d valid_left", tag, c), 32'(valid_left), 32'(evl));
    chk($sformatf("%s c%0d up", tag, c), 32'(up), 32'(eu));
    chk($sformatf("%s c%0d valid_up", tag, c), 32'(valid_up), 32'(evu));
    chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c < T + DR + 1));
    chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == T + DR));
  endtask

  task automatic run(input string tag, input bit sp, input bit wb, input bit ws, input bit spot);
    start = 1'b1;
    if (ws) drive(1, 0, $urandom_range(0, 15), 1, 0, $urandom_range(0, 15));
    for (int c = 0; c <= T + DR + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      check_cycle(c, tag);
      chk($sformatf("%s c%0d wr_err", tag, c), 32'(wr_err), 32'(wb && c == 3));
`ifdef SKEW_FEEDER_PERF_CNT_EN
      if (c > T + DR) chk($sformatf("%s c%0d cycle_cnt", tag, c), 32'(cycle_cnt), 32'(T + DR + 1));
`else
      chk($sformatf("%s c%0d cycle_cnt", tag, c), 32'(cycle_cnt), 32'd0);
`endif
      if (spot && c == 0) begin
        chk("spot t0 left", 32'(left), 32'h001);
        chk("spot t0 up", 32'(up), 32'h001);
        chk("spot t0 vl", 32'(valid_left), 32'b001);
        chk("spot t0 vu", 32'(valid_up), 32'b001);
      end
      if (spot && c == 1) begin
        chk("spot t1 left", 32'(left[7:0]), 32'h52);
        chk("spot t1 up", 32'(up[7:0]), 32'h24);
        chk("spot t1 vl", 32'(valid_left), 32'b011);
        chk("spot t1 vu", 32'(valid_up), 32'b011);
      end
      if (spot && c == 5) begin
        chk("spot t5 left2", 32'(left[11:8]), 32'd12);
        chk("spot t5 up2", 32'(up[11:8]), 32'd12);
        chk("spot t5 vl", 32'(valid_left), 32'b100);
        chk("spot t5 vu", 32'(valid_up), 32'b100);
      end
      if (sp && c == 1) start = 1'b1;
      if (wb && c == 2) begin
        wr_en_left = 1'b1; wr_addr_l = '0; wr_data_l = ~a_m[0][0];
      end
    end
  endtask

  initial begin
    vt[0] = '{1, 12, 7, 0, 0, 0, 1};
    vt[1] = '{0, 0, 0, 1, 12, 9, 1};
    vt[2] = '{1, 1023, 5, 1, 1023, 5, 1};
    vt[3] = '{1, 11, 12, 1, 11, 12, 0};
    vt[4] = '{1, 5, 6, 0, 0, 0, 0};
    vt[5] = '{0, 0, 0, 1, 0, 1, 0};
    vt[6] = '{1, 12, 3, 1, 0, 1, 1};
    vt[7] = '{0, 0, 0, 0, 0, 0, 0};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset wr_err", 32'(wr_err), 0);
    chk("reset valids", 32'({valid_left, valid_up}), 0);
    chk("reset data", 32'({left, up}), 0);
    chk("reset cycle_cnt", 32'(cycle_cnt), 0);
    rst = 1'b1;

    for (int x = 0; x < M*N; x++) begin
      drive(1, x, x + 1, 1, x, x + 1);
      @(negedge clk);
      chk($sformatf("load %0d wr_err", x), 32'(wr_err), 0);
    end
    drive(0, 0, 0, 0, 0, 0);

    for (int v = 0; v < 8; v++) begin
      drive(vt[v].el, vt[v].al, vt[v].dl, vt[v].eu, vt[v].au, vt[v].du);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("vec%0d wr_err", v), 32'(wr_err), 32'(vt[v].err));
      @(negedge clk);
      chk($sformatf("vec%0d wr_err end", v), 32'(wr_err), 0);
    end

    run("base", 0, 0, 0, 1);
    run("start_in_feed", 1, 0, 0, 0);
    run("write_busy", 0, 1, 0, 0);

    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst valids", 32'({valid_left, valid_up}), 0);
    chk("midrst done", 32'(done), 0);
    @(negedge clk);
    chk("midrst hold done", 32'(done), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst after busy", 32'(busy), 0);
    chk("midrst after done", 32'(done), 0);
    run("after_rst", 0, 0, 0, 1);
    run("write_with_start", 0, 0, 1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) begin
        bit el, eu;
        int al, au;
        el = 1'($urandom_range(0, 1)); eu = 1'($urandom_range(0, 1));
        al = $urandom_range(0, 15); au = $urandom_range(0, 15);
        drive(el, al, $urandom_range(0, 15), eu, au, $urandom_range(0, 15));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        chk($sformatf("rnd%0d.%0d wr_err", r, k), 32'(wr_err), 32'((el && al >= M*N) || (eu && au >= N*L)));
      end
      run($sformatf("rnd%0d", r), r[0], 0, r == 2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
